// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// State encoding and oversampling constants.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [3:0] TICK_S0   = 4'd7;
  localparam logic [3:0] TICK_S1   = 4'd8;
  localparam logic [3:0] TICK_VOTE = 4'd9;
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  function automatic logic vote3(input logic a,
                                 input logic b,
                                 input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an idle-high async line.
// Both stages reset to 1 so reset never fakes a start edge.
module uart_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // next-state for the two stages
  always_comb begin
    sync1_d = d_i;
    sync2_d = sync1_q;
  end

  // synchronizer flops, reset to line-idle level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q_o = sync2_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 2-of-3 mid-bit vote,
// optional parity, held byte with valid/ready consume.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic       PAR_ON   = (PARITY_EN != 0);
  localparam logic       PAR_ODD  = (PARITY_ODD != 0);

  logic rx_s;

  uart_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [3:0]           tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           samp_q, samp_d;
  logic                 par_q, par_d;
  logic                 prev_q, prev_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;
  logic                 oe_q, oe_d;
  logic                 busy_q, busy_d;

  logic fall;
  logic vote;
  logic par_bad;

  assign fall    = prev_q & ~rx_s;
  assign vote    = vote3(samp_q[0], samp_q[1], rx_s);
  assign par_bad = PAR_ON & (^shift_q ^ par_q ^ PAR_ODD);

  // frame sequencing, bit sampling and output load
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    samp_d  = samp_q;
    par_d   = par_q;
    prev_d  = rx_s;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = fe_q;
    pe_d    = pe_q;
    oe_d    = oe_q;

    if (valid_q && rx_ready) valid_d = 1'b0;

    if (state_q == RX_IDLE) begin
      if (fall) begin
        state_d = RX_START;
        tick_d  = '0;
      end
    end else if (baud_tick) begin
      tick_d = tick_q + 4'd1;
      if (tick_q == TICK_S0) samp_d[0] = rx_s;
      if (tick_q == TICK_S1) samp_d[1] = rx_s;
      unique case (state_q)
        RX_START: begin
          if (tick_q == TICK_VOTE && vote) begin
            state_d = RX_IDLE;
          end else if (tick_q == TICK_LAST) begin
            state_d = RX_DATA;
            bit_d   = '0;
          end
        end
        RX_DATA: begin
          if (tick_q == TICK_VOTE)
            shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (tick_q == TICK_LAST) begin
            if (bit_q == LAST_BIT)
              state_d = PAR_ON ? RX_PARITY : RX_STOP;
            else
              bit_d = bit_q + 3'd1;
          end
        end
        RX_PARITY: begin
          if (tick_q == TICK_VOTE) par_d = vote;
          if (tick_q == TICK_LAST) state_d = RX_STOP;
        end
        RX_STOP: begin
          if (tick_q == TICK_VOTE) begin
            state_d = RX_IDLE;
            data_d  = shift_q;
            fe_d    = ~vote;
            pe_d    = par_bad;
            oe_d    = valid_q & ~rx_ready;
            valid_d = 1'b1;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != RX_IDLE);
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      samp_q  <= 2'b11;
      par_q   <= 1'b0;
      prev_q  <= 1'b1;
      data_q  <= '0;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      samp_q  <= samp_d;
      par_q   <= par_d;
      prev_q  <= prev_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = fe_q;
  assign parity_err  = pe_q;
  assign overrun_err = oe_q;
  assign busy        = busy_q;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame (5..8), LSB first.
REQ-002 Parameter PARITY_EN, default 0, 1 = one parity bit follows the data bits.
REQ-003 Parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 baud_tick  input  1  single-cycle strobe at 16x baud rate, sourced from the baud generator stage.
REQ-007 rx  input  1  asynchronous serial line, idle high.
REQ-008 rx_ready  input  1  consumer accepts held byte when rx_valid & rx_ready.
REQ-009 rx_data  output  DATA_BITS  last received byte.
REQ-010 rx_valid  output  1  level; byte held in rx_data not yet consumed.
REQ-011 frame_err  output  1  stop bit of the held byte sampled 0.
REQ-012 parity_err  output  1  parity mismatch on the held byte; always 0 when PARITY_EN=0.
REQ-013 overrun_err  output  1  held byte overwrote an unconsumed byte.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 rx passes through a 2-flop synchronizer; both flops reset to 1; all later logic uses the synchronized value.
REQ-016 States: IDLE, START, DATA, PARITY, STOP.
REQ-017 IDLE -> START on a synchronized falling edge (previous 1, current 0), with no baud_tick required; tick_cnt (4 bits) cleared to 0.
REQ-018 Outside IDLE, tick_cnt increments on each baud_tick and wraps from 15 to 0; a bit period is 16 baud_ticks.
REQ-019 Line is sampled on baud_ticks with tick_cnt = 7, 8, 9; the bit value is the 2-of-3 majority, decided on the tick with tick_cnt = 9.
REQ-020 START: if the majority is 1, go to IDLE (false start) with no output change; otherwise advance to DATA on the tick with tick_cnt = 15.
REQ-021 DATA: shift the voted bit into the LSB-first shift register; after DATA_BITS bits, advance to PARITY if PARITY_EN=1, else to STOP, on the tick with tick_cnt = 15.
REQ-022 PARITY: store the voted bit; advance to STOP on the tick with tick_cnt = 15.
REQ-023 STOP: on the tick with tick_cnt = 9, load rx_data, frame_err (= vote==0) and parity_err, set rx_valid, and go to IDLE; the IDLE entry at mid-stop permits resync to the next start edge.
REQ-024 Output load becomes visible 1 clk after the clk edge that samples the tick with tick_cnt = 9.
REQ-025 Parity check: even parity requires XOR of data and parity bits = 0; odd parity requires it = 1.
REQ-026 rx_valid clears on the clk after the cycle with rx_valid & rx_ready; the three error flags are held with their byte.
REQ-027 Frame completes while rx_valid=1 and rx_ready=0: the new byte overwrites the held byte and overrun_err=1.
REQ-028 Frame completes in the same cycle as rx_valid & rx_ready: the new byte loads, rx_valid stays 1, overrun_err=0.
REQ-029 A line held low through reset release produces one edge at the first cycle after reset; that frame proceeds normally and may flag frame_err.

Reset
REQ-030 rst_n=0 at a clk edge: state IDLE, tick_cnt 0, shift register 0, synchronizer 1, rx_data 0, rx_valid 0, frame_err 0, parity_err 0, overrun_err 0, busy 0.
REQ-031 Reset mid-frame discards the partial frame; there is no residual output.

Structure
REQ-032 Shared package uart_pkg holds the rx state encoding and the constant OVERSAMPLE=16.
REQ-033 One sub-module, uart_sync2 (2-flop synchronizer with reset value 1), is instantiated for rx.

Verification
REQ-034 Bench setup: baud_tick is pulsed every 4 clks; one bit period is 64 clks.
REQ-035 Frame 0x55, correct stop bit, rx_ready=0 -> rx_data=0x55, rx_valid=1, all error flags 0.
REQ-036 rx low for 5 baud_ticks, then high -> no rx_valid; busy returns to 0 after the tick with tick_cnt = 9.
REQ-037 Frame 0xA3 with stop bit 0 -> rx_data=0xA3, rx_valid=1, frame_err=1.
REQ-038 PARITY_EN=1, PARITY_ODD=0, data 0x07 with parity bit 0 -> parity_err=1; the same data with parity bit 1 -> parity_err=0.
REQ-039 Frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x22, overrun_err=1; then rx_ready=1 for 1 clk -> rx_valid=0 on the next clk.
REQ-040 rst_n=0 for 1 clk during the 4th data bit -> all outputs at reset values; the next frame 0x3C is received with rx_data=0x3C and no errors.
